// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot delay, stall hold, buffered redirect.
// Optional exception entry is compiled in with `define PC_EXC_EN.
module pc_unit #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_VEC  = PC_W'(32'hBFC00000),
    parameter int              STEP       = 4,
    parameter int              BOOT_DELAY = 2
`ifdef PC_EXC_EN
    ,
    parameter logic [PC_W-1:0] EXC_VEC    = PC_W'(32'hBFC00380)
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
`ifdef PC_EXC_EN
    input  logic            exc_req,
`endif
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next,
    output logic            inst_ce,
    output logic            redirect_pending,
    output logic            misalign
);

    // state | meaning
    // BOOT  | pc parked at RESET_VEC, counting down the boot delay, fetch disabled
    // RUN   | fetch enabled, pc follows stall/redirect/sequential rules
    typedef enum logic [0:0] {BOOT = 1'b0, RUN = 1'b1} state_t;

    // BOOT_DELAY of 0 and 1 both leave BOOT on the first edge.
    localparam logic [3:0]      BOOT_LAST  = (BOOT_DELAY == 0) ? 4'd0 : 4'(BOOT_DELAY - 1);
    localparam logic [PC_W-1:0] STEP_INC   = PC_W'(STEP);
    localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);

    state_t          state_q, state_d;
    logic [3:0]      boot_cnt_q, boot_cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_q, pend_d;
    logic            inst_ce_q, inst_ce_d;
    logic            misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_d     = pend_q;
        inst_ce_d  = inst_ce_q;
        case (state_q)
            BOOT: begin
                pc_d       = RESET_VEC;
                boot_cnt_d = boot_cnt_q + 4'd1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d   = RUN;
                    inst_ce_d = 1'b1;
                end
            end
            RUN: begin
`ifdef PC_EXC_EN
                if (exc_req) begin
                    pc_d   = EXC_VEC;
                    pend_d = 1'b0;
                end else
`endif
                if (stall) begin
                    // Latest redirect seen during a stall wins.
                    if (redirect_valid) begin
                        pend_tgt_d = redirect_target;
                        pend_d     = 1'b1;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_target;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pc_d   = pend_tgt_q;
                    pend_d = 1'b0;
                end else begin
                    pc_d = pc_q + STEP_INC;
                end
            end
            default: state_d = BOOT;
        endcase
        misalign_d = |(pc_d & ALIGN_MASK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= 4'd0;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
            pend_q     <= 1'b0;
            inst_ce_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_q     <= pend_d;
            inst_ce_q  <= inst_ce_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc               = pc_q;
    assign pc_next          = pc_d;
    assign inst_ce          = inst_ce_q;
    assign redirect_pending = pend_q;
    assign misalign         = misalign_q;

endmodule
